// File: rtl/prv32_ex_mem_stage_if.sv
// Execute-to-memory stage bus: execute-side beat fields, memory-side registered beat,
// and control-flow redirect/exception sideband.
interface prv32_ex_mem_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_r;
    logic        cf;
    logic        zf;
    logic        vf;
    logic        sf;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [2:0]  funct3;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] m_result;
    logic [31:0] m_store_data;
    logic [4:0]  m_rd;
    logic        m_reg_write;
    logic        m_mem_read;
    logic        m_mem_write;
    logic        m_mem_to_reg;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_exc;
    logic [31:0] taken_count;

    modport master (
        output in_valid, alu_r, cf, zf, vf, sf, pc, imm, rs2_data, rd,
               branch, jal, jalr, reg_write, mem_read, mem_write, mem_to_reg,
               funct3, flush, out_ready,
        input  in_ready, out_valid, m_result, m_store_data, m_rd, m_reg_write,
               m_mem_read, m_mem_write, m_mem_to_reg, redirect_valid,
               redirect_pc, misalign_exc, taken_count
    );

    modport slave (
        input  in_valid, alu_r, cf, zf, vf, sf, pc, imm, rs2_data, rd,
               branch, jal, jalr, reg_write, mem_read, mem_write, mem_to_reg,
               funct3, flush, out_ready,
        output in_ready, out_valid, m_result, m_store_data, m_rd, m_reg_write,
               m_mem_read, m_mem_write, m_mem_to_reg, redirect_valid,
               redirect_pc, misalign_exc, taken_count
    );
endinterface

// File: rtl/prv32_ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution: a taken branch/jump redirects fetch
// (static not-taken predictor) and the one wrong-path beat that follows is dropped.
module prv32_ex_mem_stage (
    input  logic                 clk,
    input  logic                 rst_n,
    prv32_ex_mem_stage_if.slave  bus
);

    function automatic logic branch_cond(input logic [2:0] f3, input logic cf,
                                         input logic zf, input logic vf, input logic sf);
        logic r;
        case (f3)
            3'b000:  r = zf;
            3'b001:  r = ~zf;
            3'b100:  r = (sf != vf);
            3'b101:  r = (sf == vf);
            3'b110:  r = ~cf;
            3'b111:  r = cf;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic        out_valid_q, out_valid_d;
    logic [31:0] m_result_q, m_result_d;
    logic [31:0] m_store_data_q, m_store_data_d;
    logic [4:0]  m_rd_q, m_rd_d;
    logic        m_reg_write_q, m_reg_write_d;
    logic        m_mem_read_q, m_mem_read_d;
    logic        m_mem_write_q, m_mem_write_d;
    logic        m_mem_to_reg_q, m_mem_to_reg_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        misalign_exc_q, misalign_exc_d;
    logic [31:0] taken_count_q, taken_count_d;

    logic        in_ready_s;
    logic        accept_s;
    logic        drain_s;
    logic        taken_s;
    logic [31:0] target_s;
    logic        redirect_s;
    logic        misalign_s;

    // Handshake, branch resolution and target selection.
    always_comb begin
        in_ready_s = ~out_valid_q | bus.out_ready;
        // Wrong-path shadow beat is consumed (ready high) but never loaded.
        accept_s   = bus.in_valid & in_ready_s & ~redirect_valid_q;
        drain_s    = out_valid_q & bus.out_ready;
        taken_s    = bus.jal | bus.jalr |
                     (bus.branch & branch_cond(bus.funct3, bus.cf, bus.zf, bus.vf, bus.sf));
        if (bus.jalr) begin
            target_s = {bus.alu_r[31:1], 1'b0};
        end else begin
            target_s = bus.pc + bus.imm;
        end
        redirect_s = accept_s & ~bus.flush & taken_s & (target_s[1:0] == 2'b00);
        misalign_s = accept_s & ~bus.flush & taken_s & target_s[1];
    end

    // Next-state for the pipeline register and redirect sideband.
    always_comb begin
        out_valid_d      = out_valid_q;
        m_result_d       = m_result_q;
        m_store_data_d   = m_store_data_q;
        m_rd_d           = m_rd_q;
        m_reg_write_d    = m_reg_write_q;
        m_mem_read_d     = m_mem_read_q;
        m_mem_write_d    = m_mem_write_q;
        m_mem_to_reg_d   = m_mem_to_reg_q;
        redirect_valid_d = redirect_s;
        misalign_exc_d   = misalign_s;
        redirect_pc_d    = redirect_pc_q;
        taken_count_d    = taken_count_q;

        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d    = 1'b1;
            m_result_d     = (bus.jal | bus.jalr) ? (bus.pc + 32'd4) : bus.alu_r;
            m_store_data_d = bus.rs2_data;
            m_rd_d         = bus.rd;
            m_mem_to_reg_d = bus.mem_to_reg;
            m_reg_write_d  = bus.reg_write & ~misalign_s;
            m_mem_read_d   = bus.mem_read  & ~misalign_s;
            m_mem_write_d  = bus.mem_write & ~misalign_s;
        end else if (drain_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (redirect_s) begin
            redirect_pc_d = target_s;
            if (taken_count_q != 32'hFFFF_FFFF) begin
                taken_count_d = taken_count_q + 32'd1;
            end else begin
                taken_count_d = taken_count_q;
            end
        end else begin
            redirect_pc_d = redirect_pc_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            m_result_q       <= 32'd0;
            m_store_data_q   <= 32'd0;
            m_rd_q           <= 5'd0;
            m_reg_write_q    <= 1'b0;
            m_mem_read_q     <= 1'b0;
            m_mem_write_q    <= 1'b0;
            m_mem_to_reg_q   <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            misalign_exc_q   <= 1'b0;
            taken_count_q    <= 32'd0;
        end else begin
            out_valid_q      <= out_valid_d;
            m_result_q       <= m_result_d;
            m_store_data_q   <= m_store_data_d;
            m_rd_q           <= m_rd_d;
            m_reg_write_q    <= m_reg_write_d;
            m_mem_read_q     <= m_mem_read_d;
            m_mem_write_q    <= m_mem_write_d;
            m_mem_to_reg_q   <= m_mem_to_reg_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            misalign_exc_q   <= misalign_exc_d;
            taken_count_q    <= taken_count_d;
        end
    end

    assign bus.in_ready       = in_ready_s;
    assign bus.out_valid      = out_valid_q;
    assign bus.m_result       = m_result_q;
    assign bus.m_store_data   = m_store_data_q;
    assign bus.m_rd           = m_rd_q;
    assign bus.m_reg_write    = m_reg_write_q;
    assign bus.m_mem_read     = m_mem_read_q;
    assign bus.m_mem_write    = m_mem_write_q;
    assign bus.m_mem_to_reg   = m_mem_to_reg_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.misalign_exc   = misalign_exc_q;
    assign bus.taken_count    = taken_count_q;

endmodule

// File: tb/tb_prv32_ex_mem_stage.sv
// Directed bench for prv32_ex_mem_stage: branch/jump resolution, shadow discard,
// stall/drain, flush and asynchronous reset, with hand-computed expectations.
module tb_prv32_ex_mem_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    prv32_ex_mem_stage_if bus ();

    prv32_ex_mem_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain ALU beat: no control flow, no memory access.
    task automatic alu_beat(input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        bus.in_valid  = 1'b1;
        bus.alu_r     = alu;
        bus.rd        = rd;
        bus.reg_write = rw;
        bus.branch    = 1'b0;
        bus.jal       = 1'b0;
        bus.jalr      = 1'b0;
        bus.cf = 1'b0; bus.zf = 1'b0; bus.vf = 1'b0; bus.sf = 1'b0;
        bus.funct3    = 3'b000;
        bus.pc        = 32'h0000_0000;
        bus.imm       = 32'h0000_0000;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.alu_r = 32'd0; bus.cf = 1'b0; bus.zf = 1'b0;
        bus.vf = 1'b0; bus.sf = 1'b0; bus.pc = 32'd0; bus.imm = 32'd0;
        bus.rs2_data = 32'd0; bus.rd = 5'd0; bus.branch = 1'b0; bus.jal = 1'b0;
        bus.jalr = 1'b0; bus.reg_write = 1'b0; bus.mem_read = 1'b0;
        bus.mem_write = 1'b0; bus.mem_to_reg = 1'b0; bus.funct3 = 3'b000;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_taken_count", bus.taken_count, 32'd0);
        chk("rst_m_result", bus.m_result, 32'd0);
        #10 rst_n = 1'b1;

        // BEQ taken: pc 0x100 + 0x20
        alu_beat(32'd0, 5'd0, 1'b0);
        bus.branch = 1'b1; bus.funct3 = 3'b000; bus.zf = 1'b1;
        bus.pc = 32'h100; bus.imm = 32'h20; bus.rs2_data = 32'h55;
        tick();
        chk("beq_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("beq_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
        chk("beq_redirect_pc", bus.redirect_pc, 32'h120);
        chk("beq_taken_count", bus.taken_count, 32'd1);
        chk("beq_store_data", bus.m_store_data, 32'h55);
        // Wrong-path beat: consumed but dropped
        alu_beat(32'hDEAD, 5'd5, 1'b1);
        #1;
        chk("shadow_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("shadow_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("shadow_redirect_off", {31'd0, bus.redirect_valid}, 32'd0);
        chk("shadow_m_rd", {27'd0, bus.m_rd}, 32'd0);

        // BLT taken (sf != vf)
        alu_beat(32'h1, 5'd2, 1'b0);
        bus.branch = 1'b1; bus.funct3 = 3'b100; bus.sf = 1'b1; bus.vf = 1'b0;
        bus.pc = 32'h200; bus.imm = 32'h10;
        tick();
        chk("blt_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
        chk("blt_redirect_pc", bus.redirect_pc, 32'h210);
        chk("blt_taken_count", bus.taken_count, 32'd2);
        bus.in_valid = 1'b0;
        tick();

        // BGEU not taken (cf = 0)
        alu_beat(32'h1234, 5'd3, 1'b1);
        bus.branch = 1'b1; bus.funct3 = 3'b111; bus.cf = 1'b0;
        bus.pc = 32'h300; bus.imm = 32'h40;
        tick();
        chk("bgeu_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("bgeu_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bgeu_m_result", bus.m_result, 32'h1234);
        chk("bgeu_m_rd", {27'd0, bus.m_rd}, 32'd3);
        chk("bgeu_taken_count", bus.taken_count, 32'd2);

        // JALR to 0x202 -> misaligned
        alu_beat(32'h203, 5'd1, 1'b1);
        bus.jalr = 1'b1; bus.pc = 32'h80; bus.mem_write = 1'b1;
        tick();
        chk("jalr_misalign", {31'd0, bus.misalign_exc}, 32'd1);
        chk("jalr_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("jalr_m_reg_write", {31'd0, bus.m_reg_write}, 32'd0);
        chk("jalr_m_mem_write", {31'd0, bus.m_mem_write}, 32'd0);
        chk("jalr_m_result", bus.m_result, 32'h84);
        chk("jalr_taken_count", bus.taken_count, 32'd2);
        bus.mem_write = 1'b0;

        // JAL pc 0x80 + 0x40
        alu_beat(32'h0, 5'd1, 1'b1);
        bus.jal = 1'b1; bus.pc = 32'h80; bus.imm = 32'h40;
        tick();
        chk("jal_m_result", bus.m_result, 32'h84);
        chk("jal_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
        chk("jal_redirect_pc", bus.redirect_pc, 32'hC0);
        chk("jal_misalign", {31'd0, bus.misalign_exc}, 32'd0);
        chk("jal_m_reg_write", {31'd0, bus.m_reg_write}, 32'd1);
        chk("jal_taken_count", bus.taken_count, 32'd3);
        bus.in_valid = 1'b0;
        tick();
        chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: load A, then hold it for three cycles
        bus.out_ready = 1'b0;
        alu_beat(32'hAAAA, 5'd7, 1'b1);
        tick();
        chk("stall_load_a", bus.m_result, 32'hAAAA);
        alu_beat(32'hBBBB, 5'd8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            tick();
            chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_m_result", bus.m_result, 32'hAAAA);
            chk("stall_m_rd", {27'd0, bus.m_rd}, 32'd7);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("drain_accept_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("drain_accept_result", bus.m_result, 32'hBBBB);
        bus.in_valid = 1'b0;
        tick();
        chk("drain_empty", {31'd0, bus.out_valid}, 32'd0);

        // Flush overrides a taken acceptance
        alu_beat(32'h0, 5'd4, 1'b1);
        bus.branch = 1'b1; bus.funct3 = 3'b000; bus.zf = 1'b1;
        bus.pc = 32'h300; bus.imm = 32'h8; bus.flush = 1'b1;
        tick();
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        chk("flush_taken_count", bus.taken_count, 32'd3);
        chk("flush_m_result_held", bus.m_result, 32'hBBBB);
        bus.flush = 1'b0;

        // Two more redirects to bring taken_count to 5
        alu_beat(32'h0, 5'd1, 1'b1);
        bus.jal = 1'b1; bus.pc = 32'h400; bus.imm = 32'h10;
        tick();
        bus.in_valid = 1'b0;
        tick();
        alu_beat(32'h0, 5'd1, 1'b1);
        bus.jal = 1'b1; bus.pc = 32'h500; bus.imm = 32'h10;
        tick();
        chk("count5_redirect_pc", bus.redirect_pc, 32'h510);
        bus.in_valid = 1'b0;
        tick();

        // Stall with a valid beat, then reset asynchronously mid-cycle
        bus.out_ready = 1'b0;
        alu_beat(32'h77, 5'd9, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("prerst_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("prerst_taken_count", bus.taken_count, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_taken_count", bus.taken_count, 32'd0);
        chk("arst_m_result", bus.m_result, 32'd0);
        chk("arst_m_rd", {27'd0, bus.m_rd}, 32'd0);
        chk("arst_m_reg_write", {31'd0, bus.m_reg_write}, 32'd0);
        chk("arst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        #3 rst_n = 1'b1;
        alu_beat(32'h99, 5'd10, 1'b1);
        tick();
        chk("postrst_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("postrst_m_result", bus.m_result, 32'h99);
        bus.in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
